// File: rtl/float_add_pipe.sv
// float_add_pipe: LANES-wide, 3-stage pipelined FP add/sub with RNE rounding, flush-to-zero and overflow saturation.
// Define FLOAT_ADD_PIPE_FLAG_EN to add per-lane overflow/underflow flags on flags_o.
module float_add_pipe #(
    parameter int EW    = 8,
    parameter int MW    = 23,
    parameter int FW    = 32,
    parameter int LANES = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic                  op_sub_i,
    input  logic [LANES*FW-1:0]   data_a_i,
    input  logic [LANES*FW-1:0]   data_b_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [LANES*FW-1:0]   data_o
`ifdef FLOAT_ADD_PIPE_FLAG_EN
   ,output logic [2*LANES-1:0]    flags_o
`endif
);
    // Extended mantissa: {hidden, mantissa, guard, round, sticky}
    localparam int XW = MW + 4;
    localparam int SW = MW + 3;
    localparam logic signed [EW+1:0] E_TOP = (EW+2)'(2**EW - 1);
    localparam logic signed [EW+1:0] E_ONE = (EW+2)'(1);

    logic en;
    logic v1, v2;

    assign en         = out_ready_i | ~out_valid_o;
    assign in_ready_o = en;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            v1          <= 1'b0;
            v2          <= 1'b0;
            out_valid_o <= 1'b0;
        end else if (en) begin
            v1          <= in_valid_i;
            v2          <= v1;
            out_valid_o <= v2;
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [FW-1:0]   a, b;
        logic            sa, sb, a_big, s_big, s_sml;
        logic [EW-1:0]   ea, eb, e_big, e_sml, diff;
        logic [MW-1:0]   ma, mb;
        logic [MW:0]     m_big, m_sml;
        logic [2*SW-1:0] shf;
        int unsigned     sh;

        assign a = data_a_i[k*FW +: FW];
        assign b = data_b_i[k*FW +: FW];

        // Stage 1: flush denormals, order by magnitude, align the smaller operand
        always_comb begin
            sa    = a[FW-1];
            sb    = b[FW-1] ^ op_sub_i;
            ea    = a[FW-2 -: EW];
            eb    = b[FW-2 -: EW];
            ma    = (ea == '0) ? '0 : a[MW-1:0];
            mb    = (eb == '0) ? '0 : b[MW-1:0];
            a_big = {ea, ma} >= {eb, mb};
            if (a_big) begin
                e_big = ea;  m_big = {ea != '0, ma};  s_big = sa;
                e_sml = eb;  m_sml = {eb != '0, mb};  s_sml = sb;
            end else begin
                e_big = eb;  m_big = {eb != '0, mb};  s_big = sb;
                e_sml = ea;  m_sml = {ea != '0, ma};  s_sml = sa;
            end
            diff = e_big - e_sml;
            sh   = (32'(diff) > 32'(SW)) ? 32'(SW) : 32'(diff);
            shf  = {m_sml, 2'b00, {SW{1'b0}}} >> sh;
        end

        logic            s1_sign, s1_sub;
        logic [EW-1:0]   s1_exp;
        logic [XW-1:0]   s1_xl, s1_xs;

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                s1_sign <= 1'b0;
                s1_sub  <= 1'b0;
                s1_exp  <= '0;
                s1_xl   <= '0;
                s1_xs   <= '0;
            end else if (en) begin
                s1_sign <= s_big;
                s1_sub  <= s_big ^ s_sml;
                s1_exp  <= e_big;
                s1_xl   <= {m_big, 3'b000};
                s1_xs   <= {shf[2*SW-1:SW], |shf[SW-1:0]};
            end
        end

        logic            s2_sign;
        logic [EW-1:0]   s2_exp;
        logic [XW:0]     s2_sum;

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                s2_sign <= 1'b0;
                s2_exp  <= '0;
                s2_sum  <= '0;
            end else if (en) begin
                s2_sign <= s1_sign;
                s2_exp  <= s1_exp;
                s2_sum  <= s1_sub ? ({1'b0, s1_xl} - {1'b0, s1_xs})
                                  : ({1'b0, s1_xl} + {1'b0, s1_xs});
            end
        end

        logic [XW-1:0]          nrm;
        logic signed [EW+1:0]   e_n, e_r;
        logic [MW+1:0]          m_r;
        logic [MW-1:0]          m_out;
        int unsigned            lz;
        logic                   found, rup, zero, ovf, unf;
        logic [FW-1:0]          res;

        // Stage 3: normalise, round to nearest even, then saturate or flush
        always_comb begin
            lz    = 0;
            found = 1'b0;
            for (int unsigned i = 0; i < XW; i++) begin
                if (!found && s2_sum[XW-1-i]) begin
                    lz    = i;
                    found = 1'b1;
                end
            end
            if (s2_sum[XW]) begin
                nrm = {s2_sum[XW:2], s2_sum[1] | s2_sum[0]};
                e_n = $signed({2'b00, s2_exp}) + E_ONE;
            end else begin
                nrm = s2_sum[XW-1:0] << lz;
                e_n = $signed({2'b00, s2_exp}) - $signed((EW+2)'(lz));
            end
            rup = nrm[2] & (nrm[1] | nrm[0] | nrm[3]);
            m_r = {1'b0, nrm[XW-1:3]} + {{(MW+1){1'b0}}, rup};
            if (m_r[MW+1]) begin
                e_r   = e_n + E_ONE;
                m_out = m_r[MW:1];
            end else begin
                e_r   = e_n;
                m_out = m_r[MW-1:0];
            end
            zero = (s2_sum == '0);
            ovf  = !zero && (e_r >= E_TOP);
            unf  = !zero && (e_r < E_ONE);
            if (zero)
                res = '0;
            else if (ovf)
                res = {s2_sign, {(EW-1){1'b1}}, 1'b0, {MW{1'b1}}};
            else if (unf)
                res = {s2_sign, {(FW-1){1'b0}}};
            else
                res = {s2_sign, e_r[EW-1:0], m_out};
        end

        logic [FW-1:0] out_q;

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i)
                out_q <= '0;
            else if (en)
                out_q <= res;
        end

        assign data_o[k*FW +: FW] = out_q;

`ifdef FLOAT_ADD_PIPE_FLAG_EN
        logic ovf_q, unf_q;

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                ovf_q <= 1'b0;
                unf_q <= 1'b0;
            end else if (en) begin
                ovf_q <= ovf;
                unf_q <= unf;
            end
        end

        assign flags_o[2*k]   = ovf_q;
        assign flags_o[2*k+1] = unf_q;
`endif
    end

endmodule

// File: tb/tb_float_add_pipe.sv
// Directed self-checking bench for float_add_pipe (FP32, 4 lanes): arithmetic, latency, backpressure, reset.
module tb_float_add_pipe;
    localparam int LANES = 4;
    localparam int FW    = 32;
    localparam int LW    = LANES * FW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          op_sub = 1'b0;
    logic [LW-1:0] data_a = '0;
    logic [LW-1:0] data_b = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [LW-1:0] data_o;
`ifdef FLOAT_ADD_PIPE_FLAG_EN
    logic [2*LANES-1:0] flags;
`endif

    int total = 0;
    int bad   = 0;
    logic [31:0] fv [1:12];

    always #5 clk = ~clk;

    float_add_pipe #(
        .EW    (8),
        .MW    (23),
        .FW    (FW),
        .LANES (LANES)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .op_sub_i    (op_sub),
        .data_a_i    (data_a),
        .data_b_i    (data_b),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .data_o      (data_o)
`ifdef FLOAT_ADD_PIPE_FLAG_EN
       ,.flags_o     (flags)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One isolated beat: valid must stay low for two cycles and rise on the third
    task automatic run_one(input string tag, input logic op,
                           input logic [LW-1:0] a, input logic [LW-1:0] b, input logic [LW-1:0] e);
        @(negedge clk);
        in_valid = 1'b1; op_sub = op; data_a = a; data_b = b;
        @(negedge clk);
        in_valid = 1'b0; data_a = '0; data_b = '0;
        #1 chk($sformatf("%s_v_c1", tag), 32'(out_valid), 32'd0);
        @(negedge clk);
        #1 chk($sformatf("%s_v_c2", tag), 32'(out_valid), 32'd0);
        @(negedge clk);
        #1 chk($sformatf("%s_v_c3", tag), 32'(out_valid), 32'd1);
        for (int k = 0; k < LANES; k++)
            chk($sformatf("%s_lane%0d", tag, k), data_o[k*FW +: FW], e[k*FW +: FW]);
    endtask

    initial begin
        int tx = 0;
        int rx = 0;
        fv[1]  = 32'h3F800000; fv[2]  = 32'h40000000; fv[3]  = 32'h40400000; fv[4]  = 32'h40800000;
        fv[5]  = 32'h40A00000; fv[6]  = 32'h40C00000; fv[7]  = 32'h40E00000; fv[8]  = 32'h41000000;
        fv[9]  = 32'h41100000; fv[10] = 32'h41200000; fv[11] = 32'h41300000; fv[12] = 32'h41400000;

        #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        for (int k = 0; k < LANES; k++)
            chk($sformatf("rst_data%0d", k), data_o[k*FW +: FW], 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("rst_ready", 32'(in_ready), 32'd1);

        // Lanes: 1+1, tie-to-even down, tie-to-even up, overflow saturation
        run_one("A", 1'b0,
                {32'h7F7FFFFF, 32'h3F800001, 32'h3F800000, 32'h3F800000},
                {32'h7F7FFFFF, 32'h33800000, 32'h33800000, 32'h3F800000},
                {32'h7F7FFFFF, 32'h3F800002, 32'h3F800000, 32'h40000000});
`ifdef FLOAT_ADD_PIPE_FLAG_EN
        chk("A_flags", 32'(flags), 32'h40);
`endif
        // Lanes: exact cancel, 3-1, underflow flush, denormal b flushed
        run_one("B", 1'b1,
                {32'h40000000, 32'h00800001, 32'h40400000, 32'h3F800000},
                {32'h00000005, 32'h00800000, 32'h3F800000, 32'h3F800000},
                {32'h40000000, 32'h00000000, 32'h40000000, 32'h00000000});
`ifdef FLOAT_ADD_PIPE_FLAG_EN
        chk("B_flags", 32'(flags), 32'h20);
`endif
        run_one("C", 1'b0,
                {32'h00000000, 32'h3F800000, 32'h3F800000, 32'h00000000},
                {32'h00000000, 32'h40000000, 32'hBF800000, 32'hC0400000},
                {32'h00000000, 32'h40400000, 32'h00000000, 32'hC0400000});
        run_one("D", 1'b1,
                {32'hFF7FFFFF, 32'h3F800000, 32'h3F800000, 32'h00000000},
                {32'h7F7FFFFF, 32'h40000000, 32'h3F000000, 32'h3F800000},
                {32'hFF7FFFFF, 32'hBF800000, 32'h3F000000, 32'hBF800000});
`ifdef FLOAT_ADD_PIPE_FLAG_EN
        chk("D_flags", 32'(flags), 32'h40);
`endif

        // Eight back-to-back beats, downstream stalls on cycles 4..6
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            out_ready = !(c >= 4 && c <= 6);
            in_valid  = (tx < 8);
            op_sub    = 1'b0;
            for (int k = 0; k < LANES; k++) begin
                data_a[k*FW +: FW] = fv[tx + 1];
                data_b[k*FW +: FW] = fv[k + 1];
            end
            #1;
            if (c >= 4 && c <= 6) begin
                chk($sformatf("bp_ready_c%0d", c), 32'(in_ready), 32'd0);
                chk($sformatf("bp_valid_c%0d", c), 32'(out_valid), 32'd1);
            end
            if (out_valid) begin
                if (rx < 8) begin
                    for (int k = 0; k < LANES; k++)
                        chk($sformatf("bp_beat%0d_lane%0d", rx, k), data_o[k*FW +: FW], fv[rx + k + 2]);
                    if (out_ready) rx++;
                end else begin
                    chk("bp_extra_valid", 32'(out_valid), 32'd0);
                end
            end
            if (in_valid && in_ready) tx++;
        end
        in_valid = 1'b0;
        chk("bp_sent", 32'(tx), 32'd8);
        chk("bp_recv", 32'(rx), 32'd8);

        // Reset with one beat at the output and another still in flight
        @(negedge clk);
        out_ready = 1'b1; in_valid = 1'b1;
        for (int k = 0; k < LANES; k++) begin
            data_a[k*FW +: FW] = fv[2];
            data_b[k*FW +: FW] = fv[1];
        end
        @(negedge clk);
        for (int k = 0; k < LANES; k++) data_a[k*FW +: FW] = fv[4];
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        #1 chk("pre_rst_valid", 32'(out_valid), 32'd1);
        chk("pre_rst_lane0", data_o[31:0], fv[3]);
        rst = 1'b1;
        #1 chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_lane0", data_o[31:0], 32'h0);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #1 chk($sformatf("post_rst_idle%0d", c), 32'(out_valid), 32'd0);
        end
        run_one("post_rst", 1'b0,
                {fv[3], fv[3], fv[3], fv[3]},
                {fv[3], fv[3], fv[3], fv[3]},
                {fv[6], fv[6], fv[6], fv[6]});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/float_add_pipe.md
Name: float_add_pipe

Overview:
- Multi-lane, 3-stage pipelined floating-point adder/subtractor with valid/ready handshake.
- Parametrised successor to the combinational 2-input float add unit used in the FC accumulation path.
- Adds per-transaction add/sub mode, round-to-nearest-even, flush-to-zero, overflow saturation and backpressure.
- Sits between the FC MAC products and the partial-sum buffer; LANES independent adds per beat.

Parameters:
EW, 8, exponent width
MW, 23, mantissa width (hidden bit excluded)
FW, 32, float width; must equal EW+MW+1
LANES, 4, parallel independent adders sharing one handshake

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous reset, active-high
in_valid_i  in  1  input beat valid
in_ready_o  out  1  pipeline can accept a beat
op_sub_i  in  1  1: result = a - b; 0: a + b (applies to all lanes, sampled with beat)
data_a_i  in  LANES*FW  operand a, lane k at bits [k*FW +: FW]
data_b_i  in  LANES*FW  operand b, same packing
out_valid_o  out  1  result beat valid
out_ready_i  in  1  downstream accepts result
data_o  out  LANES*FW  results, same packing

Behaviour:
- Reset (async, rst_i=1): all stage valid bits 0, out_valid_o=0, data_o=0; in_ready_o=1 once reset is released.
- Reset mid-operation: in-flight beats are discarded, with no partial output.
- Pipeline enable: en = out_ready_i | ~out_valid_o. in_ready_o = en, combinational.
- All three stages advance together on en=1 and hold on en=0. Input is accepted when in_valid_i & in_ready_o.
- Latency is exactly 3 cycles from accept to out_valid_o with no stall. Throughput is 1 beat/cycle.
- Empty stages are bubbles; they do not collapse when en=0.
- Format: sign | EW biased exponent | MW mantissa with implicit 1.
  - Exponent field 0 means zero; denormal inputs are flushed to zero.
  - Exponent field all-ones on input is unsupported (result undefined).
- S1 align:
  - b sign ^= op_sub.
  - Compare {exp, mant}, swap so the larger magnitude is first.
  - Right-shift the smaller mantissa by the exponent difference, saturating at MW+3.
  - Keep guard and round bits; OR all shifted-out bits into sticky.
  - Result sign is the sign of the larger operand.
- S2: effective add (signs equal) or subtract on MW+4-bit extended mantissas.
- S3 normalise/round/pack:
  - Carry out: shift right 1, exponent +1.
  - Otherwise: leading-zero count, shift left, exponent minus count.
  - Rounding: round-to-nearest-even on guard/round/sticky. A rounding carry renormalises with exponent +1.
- Boundary cases:
  - Exact cancellation gives +0 (0x00000000 for FP32).
  - Either operand zero: the other operand passes through exactly, with op_sub sign applied to b.
  - Exponent < 1 after normalise flushes to signed zero.
  - Exponent ≥ 2^EW-1 saturates to the max finite value: exp = 2^EW-2, mantissa all ones, sign kept.
- Lanes are fully independent; one lane's exception never affects another lane.

Optional Feature:
- Macro: FLOAT_ADD_PIPE_FLAG_EN.
- Defined: adds output flags_o [2*LANES-1:0]. Per lane k, bit 2k = overflow (saturated) and bit 2k+1 = underflow (flushed).
  - Flags are registered alongside data_o and valid only with out_valid_o.
  - Reset value is 0.
- Undefined: no flags_o port and no flag logic; data behaviour is identical.

Test Plan:
- FP32, lane0 a=0x3F800000, b=0x3F800000, op_sub=0 -> data_o lane0=0x40000000, out_valid_o 3 cycles after accept.
- a=0x3F800000, b=0x3F800000, op_sub=1 -> 0x00000000. Also a=0x40400000 (3.0), b=0x3F800000, op_sub=1 -> 0x40000000.
- Rounding ties:
  - a=0x3F800000 + b=0x33800000 -> 0x3F800000 (tie to even).
  - a=0x3F800001 + b=0x33800000 -> 0x3F800002.
- Exceptions:
  - a=0x7F7FFFFF + b=0x7F7FFFFF -> 0x7F7FFFFF (overflow flag if FLAG_EN).
  - a=0x00800001 - b=0x00800000 -> 0x00000000 (underflow flag if FLAG_EN).
- Backpressure: stream 8 back-to-back beats with out_ready_i low for cycles 4-6.
  - in_ready_o low during the stall; no beat lost or duplicated.
  - Results appear in order, each held stable while stalled.
- Reset: assert rst_i while 2 beats are in flight -> out_valid_o=0 immediately. After release, a new beat emerges correctly after 3 cycles, with no stale output.
